// File: rtl/my_mux_nway_rr.sv
// N-channel registered mux with valid/ready on every channel; selection is either
// fixed (sel_i) or round-robin per cycle, and accepted words are counted.
module my_mux_nway_rr #(
  parameter  int WIDTH = 16,
  parameter  int N     = 8,
  localparam int SELW  = $clog2(N)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [N*WIDTH-1:0]   in_data_i,
  input  logic [N-1:0]         in_valid_i,
  output logic [N-1:0]         in_ready_o,
  input  logic [SELW-1:0]      sel_i,
  input  logic                 mode_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic [SELW-1:0]      out_chan_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [15:0]          xfer_count_o
);

  logic [N-1:0][WIDTH-1:0] ch;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [SELW-1:0]         out_chan_q, out_chan_d;
  logic                    out_valid_q, out_valid_d;
  logic [SELW-1:0]         ptr_q, ptr_d;
  logic [15:0]             xfer_q, xfer_d;
  logic                    load, gnt_vld;
  logic [SELW-1:0]         gnt, idx;
  int                      pos;

  assign ch   = in_data_i;
  assign load = !out_valid_q || out_ready_i;

  // Round-robin scans high offset to low so the last hit is the first channel
  // at or after ptr_q; selects at or beyond N never match any channel.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    pos     = 0;
    if (!mode_i) begin
      for (int i = 0; i < N; i++)
        if (sel_i == SELW'(i) && in_valid_i[i]) begin
          gnt_vld = 1'b1;
          gnt     = SELW'(i);
        end
    end else begin
      for (int k = N-1; k >= 0; k--) begin
        pos = int'(ptr_q) + k;
        if (pos >= N) pos = pos - N;
        idx = SELW'(pos);
        if (in_valid_i[idx]) begin
          gnt_vld = 1'b1;
          gnt     = idx;
        end
      end
    end
  end

  // Reset masks the handshake so no word is consumed on a reset edge.
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready_o[i] = !reset_i && load && gnt_vld && (gnt == SELW'(i));
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    xfer_d      = xfer_q;
    if (load) begin
      out_valid_d = gnt_vld;
      if (gnt_vld) begin
        out_data_d = ch[gnt];
        out_chan_d = gnt;
        xfer_d     = xfer_q + 16'd1;
        ptr_d      = (gnt == SELW'(N-1)) ? '0 : gnt + SELW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
      xfer_q      <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
      xfer_q      <= xfer_d;
    end
  end

  assign out_data_o   = out_data_q;
  assign out_chan_o   = out_chan_q;
  assign out_valid_o  = out_valid_q;
  assign xfer_count_o = xfer_q;

endmodule

// File: tb/tb_my_mux_nway_rr.sv
// Directed bench: 8x16 instance for the main scenarios, 5x16 instance for out-of-range select.
module tb_my_mux_nway_rr;
  logic clk, reset;
  int total, bad;

  logic [8*16-1:0] d8;
  logic [7:0]      v8, r8;
  logic [2:0]      s8, c8;
  logic            m8, or8, ov8;
  logic [15:0]     od8, x8;

  logic [5*16-1:0] d5;
  logic [4:0]      v5, r5;
  logic [2:0]      s5, c5;
  logic            m5, or5, ov5;
  logic [15:0]     od5, x5;

  logic [15:0] w [8];

  my_mux_nway_rr #(.WIDTH(16), .N(8)) u_dut8 (
    .clk_i(clk), .reset_i(reset), .in_data_i(d8), .in_valid_i(v8), .in_ready_o(r8),
    .sel_i(s8), .mode_i(m8), .out_data_o(od8), .out_chan_o(c8), .out_valid_o(ov8),
    .out_ready_i(or8), .xfer_count_o(x8));

  my_mux_nway_rr #(.WIDTH(16), .N(5)) u_dut5 (
    .clk_i(clk), .reset_i(reset), .in_data_i(d5), .in_valid_i(v5), .in_ready_o(r5),
    .sel_i(s5), .mode_i(m5), .out_data_o(od5), .out_chan_o(c5), .out_valid_o(ov5),
    .out_ready_i(or5), .xfer_count_o(x5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    v8 = 8'hFF; m8 = 1'b1; or8 = 1'b1; reset = 1'b1;
    #1;
    total++; if (r8 !== 8'h00) begin bad++; $display("FAIL reset_in_ready got=%h exp=00", r8); end
    tick();
    total++; if (ov8 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ov8); end
    total++; if (od8 !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0000", od8); end
    total++; if (c8 !== 3'd0) begin bad++; $display("FAIL reset_chan got=%0d exp=0", c8); end
    total++; if (x8 !== 16'd0) begin bad++; $display("FAIL reset_xfer got=%0d exp=0", x8); end
    total++; if (ov5 !== 1'b0) begin bad++; $display("FAIL reset5_valid got=%b exp=0", ov5); end
    reset = 1'b0;
  endtask

  task automatic test_fixed;
    v8 = 8'hFF; m8 = 1'b0; or8 = 1'b1;
    do_reset();
    for (int s = 0; s < 8; s++) begin
      s8 = 3'(s);
      #1;
      total++; if (r8 !== 8'(1 << s)) begin bad++; $display("FAIL fixed_rdy[%0d] got=%h exp=%h", s, r8, 8'(1 << s)); end
      tick();
      total++; if (od8 !== w[s]) begin bad++; $display("FAIL fixed_data[%0d] got=%h exp=%h", s, od8, w[s]); end
      total++; if (c8 !== 3'(s)) begin bad++; $display("FAIL fixed_chan[%0d] got=%0d exp=%0d", s, c8, s); end
    end
    total++; if (x8 !== 16'd8) begin bad++; $display("FAIL fixed_xfer got=%0d exp=8", x8); end
  endtask

  task automatic test_rr_wrap;
    v8 = 8'hFF; m8 = 1'b1; or8 = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (r8 !== 8'(1 << (i % 8))) begin bad++; $display("FAIL rr_rdy[%0d] got=%h exp=%h", i, r8, 8'(1 << (i % 8))); end
      tick();
      total++; if (c8 !== 3'(i % 8) || od8 !== w[i % 8]) begin
        bad++; $display("FAIL rr_chan[%0d] got=%0d/%h exp=%0d/%h", i, c8, od8, i % 8, w[i % 8]);
      end
    end
    total++; if (x8 !== 16'd10) begin bad++; $display("FAIL rr_xfer got=%0d exp=10", x8); end
  endtask

  task automatic test_sparse;
    int exp_g [5] = '{0, 2, 7, 0, 2};
    v8 = 8'b1000_0101; m8 = 1'b1; or8 = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (c8 !== 3'(exp_g[i]) || ov8 !== 1'b1) begin
        bad++; $display("FAIL sparse[%0d] got=%0d v=%b exp=%0d", i, c8, ov8, exp_g[i]);
      end
    end
  endtask

  task automatic test_backpressure;
    v8 = 8'hFF; m8 = 1'b0; s8 = 3'd0; or8 = 1'b1;
    do_reset();
    tick();
    s8 = 3'd1; or8 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (r8 !== 8'h00) begin bad++; $display("FAIL bp_rdy[%0d] got=%h exp=00", i, r8); end
      tick();
      total++; if (od8 !== 16'h5555 || c8 !== 3'd0 || ov8 !== 1'b1 || x8 !== 16'd1) begin
        bad++; $display("FAIL bp_hold[%0d] got=%h/%0d/%b/%0d exp=5555/0/1/1", i, od8, c8, ov8, x8);
      end
    end
    or8 = 1'b1;
    #1;
    total++; if (r8 !== 8'h02) begin bad++; $display("FAIL bp_release_rdy got=%h exp=02", r8); end
    tick();
    total++; if (od8 !== 16'hAAAA || c8 !== 3'd1 || x8 !== 16'd2) begin
      bad++; $display("FAIL bp_release got=%h/%0d/%0d exp=aaaa/1/2", od8, c8, x8);
    end
  endtask

  task automatic test_no_grant;
    v8 = 8'hFF; m8 = 1'b0; s8 = 3'd0; or8 = 1'b1;
    v5 = 5'h1F; m5 = 1'b0; s5 = 3'd0; or5 = 1'b1;
    do_reset();
    tick();
    v8 = 8'b1111_0111; s8 = 3'd3; s5 = 3'd6;
    #1;
    total++; if (r8 !== 8'h00) begin bad++; $display("FAIL nog_a_rdy got=%h exp=00", r8); end
    total++; if (r5 !== 5'h00) begin bad++; $display("FAIL nog_b_rdy got=%h exp=00", r5); end
    tick();
    total++; if (ov8 !== 1'b0 || od8 !== 16'h5555 || c8 !== 3'd0 || x8 !== 16'd1) begin
      bad++; $display("FAIL nog_a_drain got=%b/%h/%0d/%0d exp=0/5555/0/1", ov8, od8, c8, x8);
    end
    total++; if (ov5 !== 1'b0 || od5 !== 16'h1111 || x5 !== 16'd1) begin
      bad++; $display("FAIL nog_b_drain got=%b/%h/%0d exp=0/1111/1", ov5, od5, x5);
    end
    v8 = 8'hFF; m8 = 1'b1; m5 = 1'b1;
    tick();
    total++; if (c8 !== 3'd1 || ov8 !== 1'b1) begin bad++; $display("FAIL nog_a_ptr got=%0d exp=1", c8); end
    total++; if (c5 !== 3'd1 || od5 !== 16'h2222) begin bad++; $display("FAIL nog_b_ptr got=%0d/%h exp=1/2222", c5, od5); end
    v5 = 5'h00; m5 = 1'b0;
  endtask

  task automatic test_reset_mid;
    v8 = 8'hFF; m8 = 1'b0; or8 = 1'b1;
    do_reset();
    for (int s = 0; s < 5; s++) begin
      s8 = 3'(s);
      tick();
    end
    or8 = 1'b0;
    #1;
    total++; if (x8 !== 16'd5 || ov8 !== 1'b1) begin bad++; $display("FAIL mid_pre got=%0d/%b exp=5/1", x8, ov8); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++; if (ov8 !== 1'b0 || od8 !== 16'h0 || c8 !== 3'd0 || x8 !== 16'd0) begin
      bad++; $display("FAIL mid_clear got=%b/%h/%0d/%0d exp=0/0000/0/0", ov8, od8, c8, x8);
    end
    m8 = 1'b1; or8 = 1'b1;
    tick();
    total++; if (c8 !== 3'd0 || od8 !== 16'h5555 || x8 !== 16'd1) begin
      bad++; $display("FAIL mid_regrant got=%0d/%h/%0d exp=0/5555/1", c8, od8, x8);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    w = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00, 16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};
    for (int i = 0; i < 8; i++) d8[i*16 +: 16] = w[i];
    d5 = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
    reset = 1'b1; v8 = '0; s8 = '0; m8 = 1'b0; or8 = 1'b0;
    v5 = '0; s5 = '0; m5 = 1'b0; or5 = 1'b1;
    test_reset();
    test_fixed();
    test_rr_wrap();
    test_sparse();
    test_backpressure();
    test_no_grant();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
